grid_score_accum: RTL and testbench
===================================

# grid_score_accum

Sequential, parametrised score engine for the tile-grid game datapath. On a start pulse it snapshots a packed board of log2-encoded tiles. It then walks the cells one per clock, summing 2^exp for every occupied cell, and reports the total with a done pulse. It also reports the largest tile exponent (for win detection) and a saturation flag. It sits between the board-state register and the score display/BCD path.

## Interface
- CELLS, 16: number of board cells scanned.
- EXP_W, 4: bits per cell exponent code.
- SCORE_W, 32: score width. Must satisfy SCORE_W >= 2**EXP_W.
- SKIP_CODE, 12: exponent code treated as "no tile" (marker), contributes 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan. Accepted only when idle.
- board  in  CELLS*EXP_W  packed cell codes. Cell i is board[i*EXP_W +: EXP_W].
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse, results updated.
- score  out  SCORE_W  last completed sum, held until next done.
- max_exp  out  EXP_W  largest counted exponent of last scan, 0 if none.
- overflow  out  1  last sum saturated, held with score.
- clear_best  in  1  (GRID_SCORE_BEST_EN only) clear best_score.
- best_score  out  SCORE_W  (GRID_SCORE_BEST_EN only) highest score since reset/clear.

## Operation
- Cell contribution:
  - code 0 or SKIP_CODE -> 0.
  - Otherwise -> 1 << code, zero-extended to SCORE_W.
- max_exp considers only counted cells. Code 0 and SKIP_CODE are excluded.
- Accumulator is SCORE_W+1 bits. On any carry into bit SCORE_W, the sum latches all-ones and sat flag sets. Further adds keep all-ones.
- FSM states: IDLE, SCAN, DONE.
  - IDLE, start=1: latch board into snapshot, idx<=0, acc<=0, maxe<=0, sat<=0 -> SCAN.
  - IDLE, start=0: stay.
  - SCAN: add cell idx of the snapshot, update maxe, idx<=idx+1. When idx==CELLS-1 -> DONE.
  - DONE: score<=acc, max_exp<=maxe, overflow<=sat, done<=1 (next cycle only) -> IDLE.
- busy = (state != IDLE).
- start while busy is ignored. No queueing.
- board changes after the start edge do not affect the running scan (snapshot).
- idx is ceil(log2(CELLS)) bits wide, minimum 1. It never wraps past CELLS-1.

## Timing
- Start sampled at edge k.
- Cells are accumulated at edges k+1 .. k+CELLS.
- Results and done register at edge k+CELLS+1. done is high for exactly the cycle following that edge.
- Total latency is CELLS+1 clocks from the start edge to done high.
- busy is high from after edge k until after edge k+CELLS+1. It is low in the done cycle.
- Back-to-back: start asserted in the done-high cycle is accepted. Throughput is one result per CELLS+1 clocks.
- Reset values: busy 0, done 0, score 0, max_exp 0, overflow 0, best_score 0. Internal state is IDLE, idx 0.
- rst_n low mid-scan aborts immediately (asynchronous). No done is produced, and outputs return to reset values.
- Outputs are registered. There are no combinational paths from start/board to outputs.

## Configuration
- GRID_SCORE_BEST_EN defined: adds clear_best and best_score.
  - At the DONE edge: best_score <= score_new if score_new > best_score.
  - clear_best=1 at any edge sets best_score to 0.
  - If clear_best and a DONE update coincide, the clear wins.
- Undefined: no best register. Ports clear_best/best_score do not exist. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0, then release -> all outputs 0 and busy 0. Start with an all-zero board -> done at start edge+17 (CELLS=16), score=0, max_exp=0, overflow=0.
- Board with cell0=1, cell1=11, cell5=12, rest 0 -> score=2050 (0x802), max_exp=11, overflow=0.
- SCORE_W=16 instance, every cell=15 -> score=0xFFFF, overflow=1, max_exp=15. A following scan of an all-1 board -> score=32, overflow=0.
- Snapshot and busy rules:
  - Start, then change board every cycle and pulse start again mid-scan -> result matches the original board, and only one done is produced.
  - Start in the done cycle -> second done exactly 17 clocks later.
- Reset mid-scan: pull rst_n low at cycle 8 of a scan -> busy/score 0 immediately, and no done after release.
- GRID_SCORE_BEST_EN:
  - Scans scoring 100, 40, 300 -> best_score 100, 100, 300.
  - clear_best coinciding with the done edge -> best_score=0.

Source files
------------

// File: rtl/grid_score_accum.sv
// grid_score_accum: walks a snapshotted tile board one cell per clock, summing 2^code with saturation.
// Define GRID_SCORE_BEST_EN to add the best_score register and its clear_best input.
module grid_score_accum #(
   parameter int CELLS     = 16,
   parameter int EXP_W     = 4,
   parameter int SCORE_W   = 32,
   parameter int SKIP_CODE = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [CELLS*EXP_W-1:0] board,
`ifdef GRID_SCORE_BEST_EN
   input  logic                   clear_best,
   output logic [SCORE_W-1:0]     best_score,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [SCORE_W-1:0]     score,
   output logic [EXP_W-1:0]       max_exp,
   output logic                   overflow
);

   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);
   localparam logic [EXP_W-1:0] SKIP = EXP_W'(SKIP_CODE);
   localparam logic [SCORE_W:0] SAT_VAL = {1'b0, {SCORE_W{1'b1}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]             state_reg;
   logic [IDX_W-1:0]       idx_reg;
   logic [CELLS*EXP_W-1:0] snap_reg;
   logic [SCORE_W:0]       acc_reg;
   logic [EXP_W-1:0]       maxe_reg;
   logic                   sat_reg;

   logic [EXP_W-1:0]       cell_arr [CELLS];
   logic [EXP_W-1:0]       cell_code;
   logic                   counted;
   logic [SCORE_W:0]       contrib;
   logic [SCORE_W:0]       sum_wide;
   logic [SCORE_W:0]       acc_next;
   logic [EXP_W-1:0]       maxe_next;
   logic                   sat_next;

   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi = gi + 1) begin : g_cell
         assign cell_arr[gi] = snap_reg[gi*EXP_W +: EXP_W];
      end
   endgenerate

   // The accumulator's top bit stays clear, so any carry into it marks saturation.
   always_comb begin
      cell_code = cell_arr[idx_reg];
      counted   = (cell_code != '0) && (cell_code != SKIP);
      contrib   = '0;
      if (counted) begin
         contrib = {{SCORE_W{1'b0}}, 1'b1} << cell_code;
      end
      sum_wide  = acc_reg + contrib;
      sat_next  = sat_reg || sum_wide[SCORE_W];
      acc_next  = sat_next ? SAT_VAL : sum_wide;
      maxe_next = maxe_reg;
      if (counted && (cell_code > maxe_reg)) begin
         maxe_next = cell_code;
      end
   end

   assign busy = (state_reg != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         snap_reg  <= '0;
         acc_reg   <= '0;
         maxe_reg  <= '0;
         sat_reg   <= 1'b0;
         done      <= 1'b0;
         score     <= '0;
         max_exp   <= '0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  snap_reg  <= board;
                  idx_reg   <= '0;
                  acc_reg   <= '0;
                  maxe_reg  <= '0;
                  sat_reg   <= 1'b0;
                  state_reg <= SCAN;
               end
            end
            SCAN: begin
               acc_reg  <= acc_next;
               maxe_reg <= maxe_next;
               sat_reg  <= sat_next;
               if (idx_reg == IDX_LAST) begin
                  idx_reg   <= '0;
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            DONE: begin
               score     <= acc_reg[SCORE_W-1:0];
               max_exp   <= maxe_reg;
               overflow  <= sat_reg;
               done      <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef GRID_SCORE_BEST_EN
   // A clear on the same edge as a result update takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_score <= '0;
      end else if (clear_best) begin
         best_score <= '0;
      end else if ((state_reg == DONE) && (acc_reg[SCORE_W-1:0] > best_score)) begin
         best_score <= acc_reg[SCORE_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_grid_score_accum.sv
// tb_grid_score_accum: randomized scans on 32-bit and 16-bit score instances checked against an arithmetic model.
// Best-score checks are active when GRID_SCORE_BEST_EN is defined.
module tb_grid_score_accum;

   localparam int CELLS = 16;
   localparam int EXP_W = 4;
   localparam int SKIP  = 12;
   localparam int BW    = CELLS * EXP_W;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [BW-1:0] board;
   logic          busy_a, done_a, ovf_a;
   logic [31:0]   score_a;
   logic [3:0]    maxe_a;
   logic          busy_b, done_b, ovf_b;
   logic [15:0]   score_b;
   logic [3:0]    maxe_b;
`ifdef GRID_SCORE_BEST_EN
   logic          clear_best;
   logic [31:0]   best_a;
   logic [15:0]   best_b;
`endif

   int errors = 0;
   int checks = 0;
   int done_count = 0;
   longint best32 = 0;
   longint best16 = 0;

   grid_score_accum #(.CELLS(CELLS), .EXP_W(EXP_W), .SCORE_W(32), .SKIP_CODE(SKIP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .board(board),
`ifdef GRID_SCORE_BEST_EN
      .clear_best(clear_best), .best_score(best_a),
`endif
      .busy(busy_a), .done(done_a), .score(score_a), .max_exp(maxe_a), .overflow(ovf_a)
   );

   grid_score_accum #(.CELLS(CELLS), .EXP_W(EXP_W), .SCORE_W(16), .SKIP_CODE(SKIP)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .board(board),
`ifdef GRID_SCORE_BEST_EN
      .clear_best(clear_best), .best_score(best_b),
`endif
      .busy(busy_b), .done(done_b), .score(score_b), .max_exp(maxe_b), .overflow(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done_a) done_count++;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: sum of 2^code over counted cells, clipped to the score width.
   task automatic model(input logic [BW-1:0] b, input int w,
                        output longint s, output int mx, output int ov);
      longint sum = 0;
      longint lim = (longint'(1) << w) - 1;
      mx = 0;
      for (int i = 0; i < CELLS; i++) begin
         int c = int'(b[i*EXP_W +: EXP_W]);
         if (c != 0 && c != SKIP) begin
            sum += longint'(1) << c;
            if (c > mx) mx = c;
         end
      end
      ov = (sum > lim) ? 1 : 0;
      s  = (sum > lim) ? lim : sum;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy_a, 0);
      check({tag, "_done"}, done_a, 0);
      check({tag, "_score"}, score_a, 0);
      check({tag, "_maxe"}, maxe_a, 0);
      check({tag, "_ovf"}, ovf_a, 0);
      check({tag, "_score16"}, score_b, 0);
      check({tag, "_busy16"}, busy_b, 0);
`ifdef GRID_SCORE_BEST_EN
      check({tag, "_best"}, best_a, 0);
      check({tag, "_best16"}, best_b, 0);
`endif
   endtask

   // Called #1 after an edge; consumes the accepting edge.
   task automatic start_scan(input logic [BW-1:0] b);
      start = 1'b1;
      board = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [BW-1:0] b, input bit clr, input bit scramble);
      int cycles = 0;
      longint s32, s16;
      int mx32, mx16, ov32, ov16;
      bit seen = 0;
      model(b, 32, s32, mx32, ov32);
      model(b, 16, s16, mx16, ov16);
      check({tag, "_busy_start"}, busy_a, 1);
      while (cycles < 40) begin
`ifdef GRID_SCORE_BEST_EN
         if (clr && cycles == CELLS) clear_best = 1'b1;
`endif
         if (scramble) begin
            board = {$urandom, $urandom};
            start = (cycles == 5) ? 1'b1 : 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
`ifdef GRID_SCORE_BEST_EN
         clear_best = 1'b0;
`endif
         start = 1'b0;
         if (done_a) begin
            seen = 1;
            break;
         end
      end
      check({tag, "_latency"}, cycles, CELLS + 1);
      if (seen) begin
         check({tag, "_busy_done"}, busy_a, 0);
         check({tag, "_done16"}, done_b, 1);
         check({tag, "_score"}, score_a, s32);
         check({tag, "_maxe"}, maxe_a, mx32);
         check({tag, "_ovf"}, ovf_a, ov32);
         check({tag, "_score16"}, score_b, s16);
         check({tag, "_maxe16"}, maxe_b, mx16);
         check({tag, "_ovf16"}, ovf_b, ov16);
`ifdef GRID_SCORE_BEST_EN
         if (clr) begin
            best32 = 0;
            best16 = 0;
         end else begin
            if (s32 > best32) best32 = s32;
            if (s16 > best16) best16 = s16;
         end
         check({tag, "_best"}, best_a, best32);
         check({tag, "_best16"}, best_b, best16);
`endif
      end
   endtask

   function automatic logic [BW-1:0] fill(input logic [EXP_W-1:0] code);
      logic [BW-1:0] b;
      for (int i = 0; i < CELLS; i++) b[i*EXP_W +: EXP_W] = code;
      return b;
   endfunction

   function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int i, input logic [EXP_W-1:0] code);
      logic [BW-1:0] r = b;
      r[i*EXP_W +: EXP_W] = code;
      return r;
   endfunction

   initial begin
      logic [BW-1:0] b;
      int cnt;
      rst_n = 1'b0;
      start = 1'b0;
      board = '0;
`ifdef GRID_SCORE_BEST_EN
      clear_best = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      start_scan('0);
      wait_done("zero", '0, 0, 0);

      b = put(put(put('0, 0, 4'd1), 1, 4'd11), 5, 4'd12);
      start_scan(b);
      wait_done("mixed", b, 0, 0);
      $display("scan mixed: score=%0d max_exp=%0d", score_a, maxe_a);

      b = fill(4'd15);
      start_scan(b);
      wait_done("all15", b, 0, 0);
      b = fill(4'd1);
      start_scan(b);
      wait_done("all1", b, 0, 0);

      // Scores 100, 40, 300.
      b = put(put(put('0, 2, 4'd6), 7, 4'd5), 9, 4'd2);
      start_scan(b);
      wait_done("s100", b, 0, 0);
      b = put(put('0, 0, 4'd5), 15, 4'd3);
      start_scan(b);
      wait_done("s40", b, 0, 0);
      b = put(put(put(put('0, 1, 4'd8), 3, 4'd5), 4, 4'd3), 12, 4'd2);
      start_scan(b);
      wait_done("s300", b, 0, 0);
      $display("best sequence: score=%0d", score_a);

      // Board scrambled and start re-pulsed mid-scan; a single done expected.
      b = {$urandom, $urandom};
      start_scan(b);
      wait_done("snap", b, 0, 1);
      cnt = done_count;
      board = '0;
      repeat (20) @(posedge clk);
      #1;
      check("snap_single_done", done_count, cnt + 1);

      // Back-to-back: next start issued in the done cycle.
      b = {$urandom, $urandom};
      start_scan(b);
      wait_done("b2b_first", b, 0, 0);
      b = fill(4'd7);
      start_scan(b);
      wait_done("b2b_second", b, 0, 0);

      b = {$urandom, $urandom};
      start_scan(b);
      wait_done("clr_at_done", b, 1, 0);

      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < CELLS; i++) begin
            int r = $urandom_range(0, 19);
            b[i*EXP_W +: EXP_W] = (r > 15) ? ((r & 1) ? 4'd12 : 4'd0) : 4'(r);
         end
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         start_scan(b);
         wait_done("rand", b, 0, 0);
         $display("rand scan %0d: score=%0d max_exp=%0d ovf16=%0d", t, score_a, maxe_a, ovf_b);
      end

      // Asynchronous reset in the middle of a scan.
      b = fill(4'd9);
      start_scan(b);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      best32 = 0;
      best16 = 0;
      check_reset_outputs("midreset");
      cnt = done_count;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("midreset_no_done", done_count, cnt);
      check("midreset_idle", busy_a, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
